// File: rtl/decode_hazard_ctrl.sv
// Decode-stage pipeline controller: load-use and DPU scoreboard hazard
// detection, DPU issue sequencing and redirect flush generation.
module decode_hazard_ctrl #(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned MAX_DPU_OPS  = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_ni,
  input  logic                        id_valid_i,
  input  logic [$clog2(NUM_REGS)-1:0] id_rs1_i,
  input  logic [$clog2(NUM_REGS)-1:0] id_rs2_i,
  input  logic [$clog2(NUM_REGS)-1:0] id_rd_i,
  input  logic                        id_uses_rs1_i,
  input  logic                        id_uses_rs2_i,
  input  logic                        id_reg_write_i,
  input  logic                        id_is_dpu_i,
  input  logic                        ex_is_load_i,
  input  logic [$clog2(NUM_REGS)-1:0] ex_rd_i,
  input  logic                        redirect_i,
  input  logic                        dpu_ready_i,
  input  logic                        dpu_done_i,
  input  logic [$clog2(NUM_REGS)-1:0] dpu_done_rd_i,
  output logic                        stall_o,
  output logic                        flush_o,
  output logic                        issue_o,
  output logic                        dpu_req_o,
  output logic [NUM_REGS-1:0]         pending_o,
  output logic                        err_o
);

  localparam int unsigned    CW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0]  FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [2:0]     DCNT_MAX   = 3'(MAX_DPU_OPS);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       fcnt_q, fcnt_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [2:0]          dcnt_q, dcnt_d;
  logic                err_q, err_d;

  logic [NUM_REGS-1:0] done_mask, eff_pending, set_mask;
  logic                raw_dpu, waw_dpu, load_use, dpu_full, hazard;
  logic                accept, done_ok;

  // Hazard detection; a completing DPU write releases its register this cycle.
  always_comb begin
    done_mask   = dpu_done_i ? (NUM_REGS'(1) << dpu_done_rd_i) : '0;
    eff_pending = pending_q & ~done_mask;
    raw_dpu  = (id_uses_rs1_i && (id_rs1_i != '0) && eff_pending[id_rs1_i]) ||
               (id_uses_rs2_i && (id_rs2_i != '0) && eff_pending[id_rs2_i]);
    waw_dpu  = id_reg_write_i && (id_rd_i != '0) && eff_pending[id_rd_i];
    load_use = ex_is_load_i && (ex_rd_i != '0) &&
               ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));
    dpu_full = id_is_dpu_i && (dcnt_q == DCNT_MAX) && !dpu_done_i;
    hazard   = id_valid_i && (raw_dpu || waw_dpu || load_use || dpu_full);
  end

  // Pipeline control outputs; flush overrides any stall.
  always_comb begin
    flush_o   = redirect_i || (state_q == FLUSH);
    dpu_req_o = id_valid_i && id_is_dpu_i && !hazard && !flush_o;
    stall_o   = !flush_o && (hazard || (dpu_req_o && !dpu_ready_i));
    issue_o   = id_valid_i && !stall_o && !flush_o;
    pending_o = pending_q;
    err_o     = err_q;
  end

  // Flush FSM: fcnt holds the flush cycles still owed after the current one,
  // so FLUSH is left once the last owed cycle has been spent.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (redirect_i) begin
      fcnt_d  = FLUSH_LOAD;
      state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (state_q == FLUSH) begin
      fcnt_d = fcnt_q - CW'(1);
      if (fcnt_q == CW'(1)) state_d = RUN;
    end
  end

  // Scoreboard and outstanding-op counter; set beats clear on the same rd.
  always_comb begin
    accept    = dpu_req_o && dpu_ready_i;
    done_ok   = dpu_done_i && (dcnt_q != '0);
    set_mask  = (accept && id_reg_write_i && (id_rd_i != '0)) ? (NUM_REGS'(1) << id_rd_i) : '0;
    pending_d = (done_ok ? (pending_q & ~done_mask) : pending_q) | set_mask;
    dcnt_d    = dcnt_q;
    if (accept && !done_ok)      dcnt_d = dcnt_q + 3'd1;
    else if (!accept && done_ok) dcnt_d = dcnt_q - 3'd1;
    err_d     = err_q || (dpu_done_i && (dcnt_q == '0));
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst_ni) begin
    if (rst_ni) begin
      state_q   <= RUN;
      fcnt_q    <= '0;
      pending_q <= '0;
      dcnt_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      pending_q <= pending_d;
      dcnt_q    <= dcnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl: vector table, directed
// multi-cycle sequences and randomized traffic against a reference model.
module tb_decode_hazard_ctrl;

  localparam int MAXD = 2;
  localparam int FC   = 2;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        id_valid_i, id_uses_rs1_i, id_uses_rs2_i, id_reg_write_i, id_is_dpu_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i, ex_rd_i, dpu_done_rd_i;
  logic        ex_is_load_i, redirect_i, dpu_ready_i, dpu_done_i;
  logic        stall_o, flush_o, issue_o, dpu_req_o, err_o;
  logic [31:0] pending_o;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit mpend[32];
  int mcnt;
  bit merr;
  int mrem;
  bit mreq;

  typedef struct {
    int v, rs1, rs2, rd, u1, u2, wr, dpu, ld, exrd, redir, rdy;
    int es, ei, ef, er;
  } vec_t;
  vec_t tbl[13];

  decode_hazard_ctrl #(.NUM_REGS(32), .MAX_DPU_OPS(MAXD), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_ni(rst_ni),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .id_reg_write_i(id_reg_write_i), .id_is_dpu_i(id_is_dpu_i),
    .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i), .redirect_i(redirect_i),
    .dpu_ready_i(dpu_ready_i), .dpu_done_i(dpu_done_i), .dpu_done_rd_i(dpu_done_rd_i),
    .stall_o(stall_o), .flush_o(flush_o), .issue_o(issue_o), .dpu_req_o(dpu_req_o),
    .pending_o(pending_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic idle();
    id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0;
    id_uses_rs1_i = 0; id_uses_rs2_i = 0; id_reg_write_i = 0; id_is_dpu_i = 0;
    ex_is_load_i = 0; ex_rd_i = 0; redirect_i = 0; dpu_ready_i = 0;
    dpu_done_i = 0; dpu_done_rd_i = 0;
  endtask

  task automatic set_id(input int v, input int rs1, input int rs2, input int rd,
                        input int u1, input int u2, input int wr, input int dpu);
    id_valid_i = 1'(v); id_rs1_i = 5'(rs1); id_rs2_i = 5'(rs2); id_rd_i = 5'(rd);
    id_uses_rs1_i = 1'(u1); id_uses_rs2_i = 1'(u2); id_reg_write_i = 1'(wr);
    id_is_dpu_i = 1'(dpu);
  endtask

  task automatic model_reset();
    foreach (mpend[r]) mpend[r] = 0;
    mcnt = 0; merr = 0; mrem = 0; mreq = 0;
  endtask

  // Register r is still owed by an in-flight DPU op after this cycle's completion.
  function automatic bit busy(input logic [4:0] r);
    return (r != 0) && mpend[r] && !(dpu_done_i && (dpu_done_rd_i == r));
  endfunction

  // Let inputs settle, then compare every output against the model.
  task automatic settle();
    bit fl, hz, st, iss;
    logic [31:0] pv;
    #2;
    fl = redirect_i || (mrem > 0);
    hz = id_valid_i && (
           (id_uses_rs1_i && busy(id_rs1_i)) || (id_uses_rs2_i && busy(id_rs2_i)) ||
           (id_reg_write_i && busy(id_rd_i)) ||
           (ex_is_load_i && (ex_rd_i != 0) &&
            ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) || (id_uses_rs2_i && (id_rs2_i == ex_rd_i)))) ||
           (id_is_dpu_i && (mcnt == MAXD) && !dpu_done_i));
    mreq = id_valid_i && id_is_dpu_i && !hz && !fl;
    st   = !fl && (hz || (mreq && !dpu_ready_i));
    iss  = id_valid_i && !st && !fl;
    pv = '0;
    for (int r = 0; r < 32; r++) pv[r] = mpend[r];
    chk("model.stall",   32'(stall_o),   32'(st));
    chk("model.flush",   32'(flush_o),   32'(fl));
    chk("model.issue",   32'(issue_o),   32'(iss));
    chk("model.dpu_req", 32'(dpu_req_o), 32'(mreq));
    chk("model.pending", pending_o,      pv);
    chk("model.err",     32'(err_o),     32'(merr));
  endtask

  // Clock edge: advance the model with the inputs that were applied.
  task automatic adv();
    bit acc, dok;
    @(posedge clk);
    acc = mreq && dpu_ready_i;
    dok = dpu_done_i && (mcnt > 0);
    if (dpu_done_i && mcnt == 0) merr = 1;
    if (dok) mpend[dpu_done_rd_i] = 0;
    if (acc && id_reg_write_i && id_rd_i != 0) mpend[id_rd_i] = 1;
    mcnt += int'(acc) - int'(dok);
    if (redirect_i) mrem = FC - 1;
    else if (mrem > 0) mrem--;
    @(negedge clk);
  endtask

  initial begin
    idle();
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.flush",   32'(flush_o),   0);
    chk("rst.dpu_req", 32'(dpu_req_o), 0);
    chk("rst.err",     32'(err_o),     0);
    chk("rst.pending", pending_o,      0);
    chk("rst.stall",   32'(stall_o),   0);
    chk("rst.issue",   32'(issue_o),   0);
    rst_ni = 1'b0;
    @(negedge clk);

    // Combinational vectors from idle state: v rs1 rs2 rd u1 u2 wr dpu ld exrd redir rdy | stall issue flush req
    tbl[0]  = '{1,2,3,1, 1,1,1,0, 0,0, 0,0, 0,1,0,0};
    tbl[1]  = '{1,5,0,6, 1,0,1,0, 1,5, 0,0, 1,0,0,0};
    tbl[2]  = '{1,0,0,6, 1,0,1,0, 1,0, 0,0, 0,1,0,0};
    tbl[3]  = '{1,1,5,6, 1,0,1,0, 1,5, 0,0, 0,1,0,0};
    tbl[4]  = '{1,1,5,6, 1,1,1,0, 1,5, 0,0, 1,0,0,0};
    tbl[5]  = '{1,1,2,7, 1,1,1,1, 0,0, 0,1, 0,1,0,1};
    tbl[6]  = '{1,1,2,7, 1,1,1,1, 0,0, 0,0, 1,0,0,1};
    tbl[7]  = '{1,1,2,7, 1,1,1,1, 0,0, 1,1, 0,0,1,0};
    tbl[8]  = '{0,1,2,7, 1,1,1,1, 0,0, 0,1, 0,0,0,0};
    tbl[9]  = '{0,5,0,6, 1,0,1,0, 1,5, 0,0, 0,0,0,0};
    tbl[10] = '{1,5,0,6, 1,0,1,0, 1,5, 1,0, 0,0,1,0};
    tbl[11] = '{1,1,2,5, 1,1,1,0, 1,5, 0,0, 0,1,0,0};
    tbl[12] = '{1,5,0,7, 1,0,1,1, 1,5, 0,1, 1,0,0,0};
    for (int i = 0; i < 13; i++) begin
      set_id(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].u1, tbl[i].u2, tbl[i].wr, tbl[i].dpu);
      ex_is_load_i = 1'(tbl[i].ld); ex_rd_i = 5'(tbl[i].exrd);
      redirect_i = 1'(tbl[i].redir); dpu_ready_i = 1'(tbl[i].rdy);
      #2;
      chk($sformatf("vec%0d.stall", i),   32'(stall_o),   32'(tbl[i].es));
      chk($sformatf("vec%0d.issue", i),   32'(issue_o),   32'(tbl[i].ei));
      chk($sformatf("vec%0d.flush", i),   32'(flush_o),   32'(tbl[i].ef));
      chk($sformatf("vec%0d.dpu_req", i), 32'(dpu_req_o), 32'(tbl[i].er));
      idle();
      @(negedge clk);
    end

    // Load-use: one stall, then issue once the load leaves EX
    set_id(1,5,0,6, 1,0,1,0); ex_is_load_i = 1; ex_rd_i = 5;
    settle(); chk("lu.stall", 32'(stall_o), 1); adv();
    ex_is_load_i = 0; ex_rd_i = 0;
    settle(); chk("lu.issue", 32'(issue_o), 1); adv();

    // DPU rd=x7 held for three unready cycles, then accepted
    set_id(1,1,2,7, 1,1,1,1); dpu_ready_i = 0;
    for (int c = 0; c < 3; c++) begin
      settle(); chk("dpuwait.req", 32'(dpu_req_o), 1); chk("dpuwait.stall", 32'(stall_o), 1); adv();
    end
    dpu_ready_i = 1;
    settle(); chk("dpuacc.issue", 32'(issue_o), 1); adv();
    set_id(1,7,0,8, 1,1,1,0); dpu_ready_i = 0;
    settle(); chk("dep.pending7", pending_o, 32'h80); chk("dep.stall", 32'(stall_o), 1); adv();
    settle(); chk("dep.stall2", 32'(stall_o), 1); adv();
    dpu_done_i = 1; dpu_done_rd_i = 7;
    settle(); chk("dep.release_issue", 32'(issue_o), 1); adv();
    idle();
    settle(); chk("dep.pending_clear", pending_o, 0); adv();

    // DPU capacity: third op waits, issues on the completion cycle
    set_id(1,1,2,9, 1,1,1,1); dpu_ready_i = 1; settle(); adv();
    set_id(1,1,2,10, 1,1,1,1); settle(); adv();
    set_id(1,1,2,11, 1,1,1,1);
    settle(); chk("full.stall", 32'(stall_o), 1); chk("full.req", 32'(dpu_req_o), 0); adv();
    dpu_done_i = 1; dpu_done_rd_i = 9;
    settle(); chk("full.issue_on_done", 32'(issue_o), 1); chk("full.req_on_done", 32'(dpu_req_o), 1); adv();
    dpu_done_i = 0; set_id(1,1,2,12, 1,1,1,1);
    settle(); chk("full.pending", pending_o, 32'h0000_0C00); chk("full.still2", 32'(stall_o), 1); adv();
    idle(); dpu_done_i = 1; dpu_done_rd_i = 10; settle(); adv();
    dpu_done_rd_i = 11; settle(); adv();
    idle(); settle(); chk("full.drained", pending_o, 0); adv();

    // Redirect during a DPU hazard stall, then a redirect inside FLUSH
    set_id(1,1,2,13, 1,1,1,1); dpu_ready_i = 1; settle(); adv();
    set_id(1,13,1,14, 1,1,1,0); dpu_ready_i = 0;
    settle(); chk("rdir.pre_stall", 32'(stall_o), 1); adv();
    redirect_i = 1;
    settle(); chk("rdir.flush0", 32'(flush_o), 1); chk("rdir.stall0", 32'(stall_o), 0); chk("rdir.issue0", 32'(issue_o), 0); adv();
    redirect_i = 0;
    settle(); chk("rdir.flush1", 32'(flush_o), 1); chk("rdir.stall1", 32'(stall_o), 0);
    chk("rdir.pending", pending_o, 32'h2000); adv();
    settle(); chk("rdir.flush_end", 32'(flush_o), 0); chk("rdir.stall_back", 32'(stall_o), 1); adv();
    redirect_i = 1; settle(); adv();
    redirect_i = 1; settle(); adv();
    redirect_i = 0; settle(); chk("rdir2.extended", 32'(flush_o), 1); adv();
    settle(); chk("rdir2.done", 32'(flush_o), 0); adv();
    idle(); dpu_done_i = 1; dpu_done_rd_i = 13; settle(); adv();

    // Spurious completion sets sticky error
    dpu_done_i = 1; dpu_done_rd_i = 3; settle(); adv();
    idle(); settle(); chk("err.set", 32'(err_o), 1); adv();
    settle(); chk("err.sticky", 32'(err_o), 1); adv();

    // Asynchronous reset mid-operation
    set_id(1,1,2,20, 1,1,1,1); dpu_ready_i = 1; settle(); adv();
    idle(); redirect_i = 1; settle(); adv();
    idle(); #2;
    rst_ni = 1'b1; #1;
    chk("arst.pending", pending_o, 0);
    chk("arst.err",     32'(err_o),   0);
    chk("arst.flush",   32'(flush_o), 0);
    #1 rst_ni = 1'b0;
    model_reset();
    @(negedge clk);
    dpu_done_i = 1; dpu_done_rd_i = 20; settle(); adv();
    idle(); settle(); chk("arst.late_done_err", 32'(err_o), 1); adv();

    #2 rst_ni = 1'b1; #1 rst_ni = 1'b0;
    model_reset();
    @(negedge clk);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      set_id(($urandom_range(0, 9) < 8) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), ($urandom_range(0, 9) < 3) ? 1 : 0);
      ex_is_load_i = ($urandom_range(0, 3) == 0);
      ex_rd_i      = 5'($urandom_range(0, 7));
      redirect_i   = ($urandom_range(0, 19) == 0);
      dpu_ready_i  = ($urandom_range(0, 9) < 6);
      if (mcnt > 0) dpu_done_i = ($urandom_range(0, 9) < 3);
      else          dpu_done_i = ($urandom_range(0, 49) == 0);
      dpu_done_rd_i = 5'($urandom_range(0, 7));
      settle();
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
